// File: rtl/vga_scandoubler_pkg.sv
// Shared video definitions for the 15 kHz -> 31 kHz scandoubler.
package vga_scandoubler_pkg;

  localparam int   COLOUR_W    = 3;
  localparam int   PIXEL_W     = 3 * COLOUR_W;
  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic [COLOUR_W-1:0] r;
    logic [COLOUR_W-1:0] g;
    logic [COLOUR_W-1:0] b;
  } pixel_t;

  // Halve each component: used to darken the repeated copy of a line.
  function automatic pixel_t scanline_dim(input pixel_t p);
    pixel_t d;
    d.r = {1'b0, p.r[COLOUR_W-1:1]};
    d.g = {1'b0, p.g[COLOUR_W-1:1]};
    d.b = {1'b0, p.b[COLOUR_W-1:1]};
    return d;
  endfunction

endpackage

// File: rtl/vga_scandoubler_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, one write port, one registered read port.
module scandoubler_linebuf
  import vga_scandoubler_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [ADDR_W:0] waddr_i,
  input  pixel_t          wdata_i,
  input  logic [ADDR_W:0] raddr_i,
  output pixel_t          rdata_o
);

  localparam int DEPTH = 2 ** (ADDR_W + 1);

  pixel_t mem [DEPTH];

  // Read-before-write on an address collision: the reader sees the old line.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/vga_scandoubler.sv
// 15 kHz RGB333 to 31 kHz VGA scandoubler with registered passthrough mode.
// Optional VGA_SCANLINES_EN: darken the second copy of each line when scanlines_enable=1.
module vga_scandoubler
  import vga_scandoubler_pkg::*;
#(
  parameter int ADDR_W    = 9,
  parameter int HSYNC_LEN = 54
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clken_src,
  input  logic                clken_dbl,
  input  logic                scandbl_enable,
  input  logic                scanlines_enable,
  input  logic [COLOUR_W-1:0] ri,
  input  logic [COLOUR_W-1:0] gi,
  input  logic [COLOUR_W-1:0] bi,
  input  logic                hsync_in,
  input  logic                vsync_in,
  output logic [COLOUR_W-1:0] ro,
  output logic [COLOUR_W-1:0] go,
  output logic [COLOUR_W-1:0] bo,
  output logic                hsync_out,
  output logic                vsync_out
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_W-1:0] HS_END   = ADDR_W'(HSYNC_LEN);

  logic              hs_prev_q, hs_prev_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] rd_end_q, rd_end_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rep_q, rep_d;
  logic              vs_line_q, vs_line_d;
  logic              mode_q, mode_d;
  logic              hs_fall, rd_zero, hs_vga;
  logic              s1_hs_q, s1_vs_q;
  pixel_t            wr_pix, rd_pix, vga_pix;
  pixel_t            pix_q, pix_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d;

  assign hs_fall = clken_src & hs_prev_q & ~hsync_in;
  assign wr_pix  = {ri, gi, bi};

  // Write side: the pixel coincident with hs_fall lands at address 0 of the new bank.
  always_comb begin
    hs_prev_d = hs_prev_q;
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    rd_end_d  = rd_end_q;
    if (clken_src) hs_prev_d = hsync_in;
    if (hs_fall) begin
      wr_bank_d = ~wr_bank_q;
      wr_addr_d = '0;
      rd_end_d  = wr_addr_q;
    end else if (clken_src && wr_addr_q != ADDR_MAX) begin
      wr_addr_d = wr_addr_q + 1'b1;
    end
  end

  // Read side: hs_fall re-aligns the output line pair to the source line.
  always_comb begin
    rd_addr_d = rd_addr_q;
    rep_d     = rep_q;
    rd_zero   = 1'b0;
    if (hs_fall) begin
      rd_addr_d = '0;
      rep_d     = 1'b0;
      rd_zero   = 1'b1;
    end else if (clken_dbl) begin
      if (rd_addr_q == rd_end_q) begin
        rd_addr_d = '0;
        rep_d     = ~rep_q;
        rd_zero   = 1'b1;
      end else begin
        rd_addr_d = rd_addr_q + 1'b1;
      end
    end
    vs_line_d = rd_zero ? vsync_in : vs_line_q;
  end

  assign hs_vga = (rd_addr_q < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

  scandoubler_linebuf #(.ADDR_W(ADDR_W)) u_linebuf (
    .clk     (clk),
    .we_i    (clken_src),
    .waddr_i ({wr_bank_d, wr_addr_d}),
    .wdata_i (wr_pix),
    .raddr_i ({~wr_bank_q, rd_addr_q}),
    .rdata_o (rd_pix)
  );

`ifdef VGA_SCANLINES_EN
  logic s1_rep_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_rep_q <= 1'b0;
    else        s1_rep_q <= rep_q;
  end

  assign vga_pix = (scanlines_enable && s1_rep_q) ? scanline_dim(rd_pix) : rd_pix;
`else
  logic unused_scanlines;
  assign unused_scanlines = scanlines_enable;
  assign vga_pix = rd_pix;
`endif

  // Mode is only sampled on a source pixel so a switch never splits a pixel.
  always_comb begin
    mode_d  = clken_src ? scandbl_enable : mode_q;
    pix_d   = pix_q;
    hsync_d = hsync_q;
    vsync_d = vsync_q;
    if (mode_d) begin
      pix_d   = vga_pix;
      hsync_d = s1_hs_q;
      vsync_d = s1_vs_q;
    end else if (clken_src) begin
      pix_d   = wr_pix;
      hsync_d = hsync_in;
      vsync_d = vsync_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_prev_q <= 1'b1;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
      rd_end_q  <= '0;
      wr_bank_q <= 1'b0;
      rep_q     <= 1'b0;
      vs_line_q <= ~SYNC_ACTIVE;
      mode_q    <= 1'b1;
      s1_hs_q   <= ~SYNC_ACTIVE;
      s1_vs_q   <= ~SYNC_ACTIVE;
      pix_q     <= '0;
      hsync_q   <= ~SYNC_ACTIVE;
      vsync_q   <= ~SYNC_ACTIVE;
    end else begin
      hs_prev_q <= hs_prev_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
      rd_end_q  <= rd_end_d;
      wr_bank_q <= wr_bank_d;
      rep_q     <= rep_d;
      vs_line_q <= vs_line_d;
      mode_q    <= mode_d;
      s1_hs_q   <= hs_vga;
      s1_vs_q   <= vs_line_q;
      pix_q     <= pix_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
    end
  end

  assign ro        = pix_q.r;
  assign go        = pix_q.g;
  assign bo        = pix_q.b;
  assign hsync_out = hsync_q;
  assign vsync_out = vsync_q;

endmodule

// File: tb/tb_vga_scandoubler.sv
// Self-checking bench: passthrough vector table, line-level VGA reference model, corner sequences.
module tb_vga_scandoubler;

  logic       clk, rst_n, clken_src, clken_dbl, scandbl_enable, scanlines_enable;
  logic [2:0] ri, gi, bi, ro, go, bo;
  logic       hsync_in, vsync_in, hsync_out, vsync_out;

  vga_scandoubler dut (
    .clk(clk), .rst_n(rst_n), .clken_src(clken_src), .clken_dbl(clken_dbl),
    .scandbl_enable(scandbl_enable), .scanlines_enable(scanlines_enable),
    .ri(ri), .gi(gi), .bi(bi), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .ro(ro), .go(go), .bo(bo), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic vga_chk = 1'b0;

  typedef struct {
    logic [8:0] pix;
    logic       hs;
    logic       vs;
    logic [8:0] exp_pix;
    logic       exp_hs;
    logic       exp_vs;
  } pt_vec_t;

  typedef struct packed {
    logic       v;
    logic [8:0] pix;
    logic       hs;
    logic       vs;
    logic       rep;
  } rec_t;

  // Reference model: whole source lines held as pixel queues, output position from elapsed time.
  logic [8:0] m_cur[$];
  logic [8:0] m_prev[$];
  logic       m_cur_ok, m_prev_ok, m_hs_prev, m_vs;
  int         m_nfall, m_fall_cyc;
  rec_t       pipe [3];

  // Monitors for pulse widths and spacing.
  logic mon_en = 1'b0;
  logic prev_hs, prev_vs;
  int   hs_lo, hs_edges, hs_e0, hs_e1, vs_lo, vs_edges;

  function automatic logic [8:0] dim9(input logic [8:0] p);
    logic [2:0] r, g, b;
    r = p[8:6] / 3'd2;
    g = p[5:3] / 3'd2;
    b = p[2:0] / 3'd2;
    return {r, g, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_cur.delete();
    m_cur.push_back(9'h000);
    m_prev.delete();
    m_prev.push_back(9'h000);
    m_cur_ok  = 1'b0;
    m_prev_ok = 1'b0;
    m_hs_prev = 1'b1;
    m_vs      = 1'b1;
    m_nfall   = 0;
    m_fall_cyc = 0;
    for (int i = 0; i < 3; i++) pipe[i] = '0;
  endtask

  task automatic model_edge(input logic src, input logic dbl, input logic [8:0] pix,
                            input logic hs, input logic vs);
    logic fall, zero;
    int k, len, pos;
    rec_t r;
    fall = src && m_hs_prev && !hs;
    if (src) begin
      if (fall) begin
        m_prev = m_cur;
        m_prev_ok = m_cur_ok;
        m_cur.delete();
        m_cur.push_back(pix);
        m_cur_ok = 1'b1;
        m_fall_cyc = cyc;
        m_nfall++;
      end else if (m_cur.size() < 512) begin
        m_cur.push_back(pix);
      end else begin
        m_cur[511] = pix;
      end
      m_hs_prev = hs;
    end
    r = '0;
    if (m_nfall == 0) begin
      zero = dbl;
    end else begin
      k    = (cyc - m_fall_cyc) / 2;
      len  = m_prev.size();
      pos  = k % len;
      zero = fall || (dbl && k > 0 && pos == 0);
      r.v   = m_prev_ok;
      r.pix = m_prev[pos];
      r.hs  = (pos < 54) ? 1'b0 : 1'b1;
      r.rep = ((k / len) % 2) == 1;
    end
    if (zero) m_vs = vs;
    r.vs = m_vs;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = r;
  endtask

  task automatic check_cycle();
    logic [8:0] epix;
    if (vga_chk && pipe[2].v) begin
      epix = pipe[2].pix;
`ifdef VGA_SCANLINES_EN
      if (scanlines_enable && pipe[2].rep) epix = dim9(epix);
`endif
      chk("vga_model", {21'd0, ro, go, bo, hsync_out, vsync_out},
          {21'd0, epix, pipe[2].hs, pipe[2].vs});
    end
    if (mon_en) begin
      if (!hsync_out) hs_lo++;
      if (!vsync_out) vs_lo++;
      if (prev_hs && !hsync_out) begin
        if (hs_edges == 0) hs_e0 = cyc;
        if (hs_edges == 1) hs_e1 = cyc;
        hs_edges++;
      end
      if (prev_vs && !vsync_out) vs_edges++;
      prev_hs = hsync_out;
      prev_vs = vsync_out;
    end
  endtask

  task automatic mon_start();
    mon_en = 1'b1;
    hs_lo = 0; hs_edges = 0; hs_e0 = 0; hs_e1 = 0; vs_lo = 0; vs_edges = 0;
    prev_hs = hsync_out;
    prev_vs = vsync_out;
  endtask

  // One clk: drive at negedge, update model at posedge, check at the next negedge.
  task automatic tick(input logic [8:0] pix, input logic hs, input logic vs);
    logic src, dbl;
    src = (cyc % 4) == 0;
    dbl = (cyc % 2) == 0;
    clken_src = src;
    clken_dbl = dbl;
    {ri, gi, bi} = pix;
    hsync_in = hs;
    vsync_in = vs;
    @(posedge clk);
    model_edge(src, dbl, pix, hs, vs);
    cyc++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic align();
    while (cyc % 4 != 0) tick(9'h000, 1'b1, 1'b1);
  endtask

  // kind: 0 ramp, 1 all 9'h1FF, 2 random. Pixels base..base+n-1 of a line.
  task automatic drive_px(input int n, input int kind, input int base, input int hs_low,
                          input logic vs, input logic hs_en);
    logic [8:0] p;
    logic hs;
    for (int i = 0; i < n; i++) begin
      case (kind)
        0:       p = 9'(base + i);
        1:       p = 9'h1FF;
        default: p = 9'($urandom);
      endcase
      hs = (hs_en && (base + i) < hs_low) ? 1'b0 : 1'b1;
      for (int t = 0; t < 4; t++) tick(p, hs, vs);
    end
  endtask

  task automatic line(input int len, input int kind, input logic vs);
    drive_px(len, kind, 0, 32, vs, 1'b1);
  endtask

  pt_vec_t tbl [8];
  logic [8:0] exp2;

  initial begin
    tbl[0] = '{pix:9'h000, hs:1'b1, vs:1'b1, exp_pix:9'h000, exp_hs:1'b1, exp_vs:1'b1};
    tbl[1] = '{pix:9'h1FF, hs:1'b1, vs:1'b1, exp_pix:9'h1FF, exp_hs:1'b1, exp_vs:1'b1};
    tbl[2] = '{pix:9'h0A5, hs:1'b0, vs:1'b1, exp_pix:9'h0A5, exp_hs:1'b0, exp_vs:1'b1};
    tbl[3] = '{pix:9'h15A, hs:1'b0, vs:1'b0, exp_pix:9'h15A, exp_hs:1'b0, exp_vs:1'b0};
    tbl[4] = '{pix:9'h123, hs:1'b1, vs:1'b0, exp_pix:9'h123, exp_hs:1'b1, exp_vs:1'b0};
    tbl[5] = '{pix:9'h0DB, hs:1'b1, vs:1'b1, exp_pix:9'h0DB, exp_hs:1'b1, exp_vs:1'b1};
    tbl[6] = '{pix:9'h1C7, hs:1'b0, vs:1'b1, exp_pix:9'h1C7, exp_hs:1'b0, exp_vs:1'b1};
    tbl[7] = '{pix:9'h038, hs:1'b1, vs:1'b1, exp_pix:9'h038, exp_hs:1'b1, exp_vs:1'b1};

    rst_n = 1'b0; clken_src = 1'b0; clken_dbl = 1'b0;
    scandbl_enable = 1'b1; scanlines_enable = 1'b0;
    {ri, gi, bi} = 9'h000; hsync_in = 1'b1; vsync_in = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("reset_out", {21'd0, ro, go, bo, hsync_out, vsync_out}, 32'h003);

    // First line after reset: rd_end=0 so the read address sits at 0 inside the hsync pulse.
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) tick(9'h000, 1'b1, 1'b1);
    chk("rdend0_hsync", {31'd0, hsync_out}, 32'd0);
    for (int i = 0; i < 300; i++) tick(9'h000, 1'b1, 1'b1);
    chk("rdend0_hsync_hold", {31'd0, hsync_out}, 32'd0);

    // Passthrough table.
    align();
    scandbl_enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick(tbl[i].pix, tbl[i].hs, tbl[i].vs);
      chk("pt_out", {21'd0, ro, go, bo, hsync_out, vsync_out},
          {21'd0, tbl[i].exp_pix, tbl[i].exp_hs, tbl[i].exp_vs});
      for (int t = 0; t < 3; t++) tick(~tbl[i].pix, ~tbl[i].hs, ~tbl[i].vs);
      chk("pt_hold", {21'd0, ro, go, bo, hsync_out, vsync_out},
          {21'd0, tbl[i].exp_pix, tbl[i].exp_hs, tbl[i].exp_vs});
    end

    // VGA mode with the reference model running.
    scandbl_enable = 1'b1;
    for (int i = 0; i < 8; i++) tick(9'h000, 1'b1, 1'b1);
    vga_chk = 1'b1;
    for (int l = 0; l < 3; l++) line(448, 0, 1'b1);
    mon_start();
    line(448, 0, 1'b1);
    mon_en = 1'b0;
    chk("hs_pulses", 32'(hs_edges), 32'd2);
    chk("hs_low_clks", 32'(hs_lo), 32'd216);
    chk("hs_spacing", 32'(hs_e1 - hs_e0), 32'd896);

    mon_start();
    for (int l = 0; l < 4; l++) line(448, 2, 1'b0);
    for (int l = 0; l < 2; l++) line(448, 2, 1'b1);
    mon_en = 1'b0;
    chk("vs_edges", 32'(vs_edges), 32'd1);
    chk("vs_low_clks", 32'(vs_lo), 32'd7168);

    // Scanlines: first copy full, second copy darkened only when the option is built in.
    scanlines_enable = 1'b1;
    line(448, 1, 1'b1);
    drive_px(25, 0, 0, 32, 1'b1, 1'b1);
    chk("scan_copy1", {23'd0, ro, go, bo}, 32'h1FF);
`ifdef VGA_SCANLINES_EN
    exp2 = 9'h0DB;
`else
    exp2 = 9'h1FF;
`endif
    drive_px(225, 0, 25, 32, 1'b1, 1'b1);
    chk("scan_copy2", {23'd0, ro, go, bo}, {23'd0, exp2});
    drive_px(198, 0, 250, 32, 1'b1, 1'b1);
    scanlines_enable = 1'b0;

    // Random short/long lines.
    for (int l = 0; l < 4; l++)
      drive_px($urandom_range(300, 500), 2, 0, $urandom_range(8, 64), 1'($urandom), 1'b1);

    // Missing hsync: write saturates at 511, next line reads 512 entries.
    drive_px(600, 0, 0, 32, 1'b1, 1'b0);
    mon_start();
    line(448, 0, 1'b1);
    mon_en = 1'b0;
    chk("sat_hs_spacing", 32'(hs_e1 - hs_e0), 32'd1024);
    chk("sat_hs_pulses", 32'(hs_edges), 32'd2);
    for (int l = 0; l < 2; l++) line(448, 2, 1'b1);

    // Asynchronous reset in the middle of a line.
    drive_px(100, 2, 0, 32, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {21'd0, ro, go, bo, hsync_out, vsync_out}, 32'h003);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    align();
    for (int l = 0; l < 4; l++) line(448, 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
